scnn_mac_cord_unit: RTL and testbench

Per-cycle compute core of the SCNN processing element (PE). It forms the 4×4 Cartesian product of four compressed non-zero weights and four compressed non-zero input activations, giving 16 signed products. In parallel it decodes the zero-run compressed indices back to dense positions and maps each product to a flattened output-activation coordinate. It sits between the PE's operand-fetch registers and its accumulator scatter logic.

---
 rtl/scnn_mac_cord_unit.sv | 180 ++++++++++++++++++
 tb/tb_scnn_mac_cord_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/scnn_mac_cord_unit.sv
`default_nettype none
// ============================================================================
// Module      : scnn_mac_cord_unit
// Description : SCNN PE compute core. Forms the 4x4 Cartesian product of four
//               compressed weights and four compressed activations, decodes
//               the zero-run indices to dense positions and maps every product
//               to a flattened output coordinate (8'hFF marks invalid).
//               One register stage from inputs to outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module scnn_mac_cord_unit (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [3:0][15:0] wts_to_mult,
    input  logic [3:0][15:0] ips_to_mult,
    input  logic [3:0][3:0]  wts_inds_comp,
    input  logic [3:0][7:0]  ips_inds_comp,
    input  logic [3:0]       wts_offset,
    input  logic [7:0]       ips_offset,
    input  logic [3:0]       wt_dim,
    input  logic [7:0]       ip_dim,
    output logic             out_valid,
    output logic [15:0][31:0] ops_from_mult,
    output logic [15:0][7:0] ops_cords,
    output logic [3:0][3:0]  original_wt_ind,
    output logic [3:0][7:0]  original_ip_ind,
    output logic [3:0]       last_wt_ind,
    output logic [7:0]       last_ip_ind
);

    localparam logic [7:0] c_INVALID = 8'hFF;

    // Decoded dense positions, kept wide so overruns are still detectable
    logic [11:0]         w_wt_pos [4];
    logic [11:0]         w_ip_pos [4];
    logic [11:0]         w_wt_acc;
    logic [11:0]         w_ip_acc;

    // Row/column split of each position
    logic [11:0]         w_wt_div;
    logic [11:0]         w_ip_div;
    logic [11:0]         w_wt_row [4];
    logic [11:0]         w_wt_col [4];
    logic [11:0]         w_ip_row [4];
    logic [11:0]         w_ip_col [4];

    // Geometry
    logic [11:0]         w_rr;
    logic [15:0]         w_ww;
    logic signed [13:0]  w_o;
    logic                w_dim_bad;

    // Per-entry scratch for the coordinate computation
    logic signed [13:0]  w_r;
    logic signed [13:0]  w_c;
    logic signed [27:0]  w_coord;
    logic                w_bad;

    logic signed [15:0]  w_wt_s [4];
    logic signed [15:0]  w_ip_s [4];

    logic [15:0][31:0]   w_prod_calc;
    logic [15:0][7:0]    w_cords_calc;

    // Next-state values
    logic                w_valid_d;
    logic [15:0][31:0]   w_prod_d;
    logic [15:0][7:0]    w_cords_d;
    logic [3:0][3:0]     w_orig_wt_d;
    logic [3:0][7:0]     w_orig_ip_d;

    // Registered state
    logic                r_valid_q;
    logic [15:0][31:0]   r_prod_q;
    logic [15:0][7:0]    r_cords_q;
    logic [3:0][3:0]     r_orig_wt_q;
    logic [3:0][7:0]     r_orig_ip_q;

    // Zero-run decode: running sum of offset, run lengths and one step per non-zero
    always_comb begin
        w_wt_acc = 12'(wts_offset);
        w_ip_acc = 12'(ips_offset);
        for (int i = 0; i < 4; i++) begin
            w_wt_acc    = w_wt_acc + 12'(wts_inds_comp[i]);
            w_ip_acc    = w_ip_acc + 12'(ips_inds_comp[i]);
            w_wt_pos[i] = w_wt_acc;
            w_ip_pos[i] = w_ip_acc;
            w_wt_acc    = w_wt_acc + 12'd1;
            w_ip_acc    = w_ip_acc + 12'd1;
        end
    end

    // A zero side would divide by zero; such sets are flagged invalid anyway,
    // so a divisor of one just keeps the arithmetic defined.
    assign w_wt_div  = (wt_dim == 4'd0) ? 12'd1 : 12'(wt_dim);
    assign w_ip_div  = (ip_dim == 8'd0) ? 12'd1 : 12'(ip_dim);
    assign w_rr      = 12'(wt_dim) * 12'(wt_dim);
    assign w_ww      = 16'(ip_dim) * 16'(ip_dim);
    assign w_o       = $signed({6'b0, ip_dim}) - $signed({10'b0, wt_dim}) + 14'sd1;
    assign w_dim_bad = (wt_dim == 4'd0) || (12'(wt_dim) > 12'(ip_dim));

    for (genvar g = 0; g < 4; g++) begin : g_pos
        assign w_wt_row[g] = w_wt_pos[g] / w_wt_div;
        assign w_wt_col[g] = w_wt_pos[g] % w_wt_div;
        assign w_ip_row[g] = w_ip_pos[g] / w_ip_div;
        assign w_ip_col[g] = w_ip_pos[g] % w_ip_div;
        assign w_wt_s[g]   = $signed(wts_to_mult[g]);
        assign w_ip_s[g]   = $signed(ips_to_mult[g]);
    end

    // Cartesian product and output coordinate for every weight/activation pair
    always_comb begin
        w_r          = '0;
        w_c          = '0;
        w_coord      = '0;
        w_bad        = 1'b0;
        w_prod_calc  = '0;
        w_cords_calc = '0;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 4; n++) begin
                w_prod_calc[4*k+n] = 32'(w_wt_s[k]) * 32'(w_ip_s[n]);
                w_r     = $signed({2'b00, w_ip_row[n]}) - $signed({2'b00, w_wt_row[k]});
                w_c     = $signed({2'b00, w_ip_col[n]}) - $signed({2'b00, w_wt_col[k]});
                w_coord = 28'(w_r) * 28'(w_o) + 28'(w_c);
                w_bad   = w_dim_bad
                        || (w_wt_pos[k] >= w_rr)
                        || (16'(w_ip_pos[n]) >= w_ww)
                        || (w_r < 14'sd0) || (w_r >= w_o)
                        || (w_c < 14'sd0) || (w_c >= w_o)
                        || (w_coord >= 28'sd255);
                w_cords_calc[4*k+n] = w_bad ? c_INVALID : w_coord[7:0];
            end
        end
    end

    // Load a new operand set when valid, otherwise hold the data registers
    always_comb begin
        w_valid_d   = in_valid;
        w_prod_d    = r_prod_q;
        w_cords_d   = r_cords_q;
        w_orig_wt_d = r_orig_wt_q;
        w_orig_ip_d = r_orig_ip_q;
        if (in_valid) begin
            w_prod_d  = w_prod_calc;
            w_cords_d = w_cords_calc;
            for (int i = 0; i < 4; i++) begin
                w_orig_wt_d[i] = w_wt_pos[i][3:0];
                w_orig_ip_d[i] = w_ip_pos[i][7:0];
            end
        end
    end

    // Single output register bank with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q   <= 1'b0;
            r_prod_q    <= '0;
            r_cords_q   <= {16{c_INVALID}};
            r_orig_wt_q <= '0;
            r_orig_ip_q <= '0;
        end else begin
            r_valid_q   <= w_valid_d;
            r_prod_q    <= w_prod_d;
            r_cords_q   <= w_cords_d;
            r_orig_wt_q <= w_orig_wt_d;
            r_orig_ip_q <= w_orig_ip_d;
        end
    end

    assign out_valid       = r_valid_q;
    assign ops_from_mult   = r_prod_q;
    assign ops_cords       = r_cords_q;
    assign original_wt_ind = r_orig_wt_q;
    assign original_ip_ind = r_orig_ip_q;
    assign last_wt_ind     = r_orig_wt_q[3];
    assign last_ip_ind     = r_orig_ip_q[3];

endmodule
`default_nettype wire

// File: tb/tb_scnn_mac_cord_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_scnn_mac_cord_unit
// Description : Directed self-checking bench for scnn_mac_cord_unit with
//               hand-computed expected products, indices and coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scnn_mac_cord_unit;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [3:0][15:0]  wts_to_mult;
    logic [3:0][15:0]  ips_to_mult;
    logic [3:0][3:0]   wts_inds_comp;
    logic [3:0][7:0]   ips_inds_comp;
    logic [3:0]        wts_offset;
    logic [7:0]        ips_offset;
    logic [3:0]        wt_dim;
    logic [7:0]        ip_dim;
    logic              out_valid;
    logic [15:0][31:0] ops_from_mult;
    logic [15:0][7:0]  ops_cords;
    logic [3:0][3:0]   original_wt_ind;
    logic [3:0][7:0]   original_ip_ind;
    logic [3:0]        last_wt_ind;
    logic [7:0]        last_ip_ind;

    int n_chk;
    int n_err;

    scnn_mac_cord_unit u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .wts_to_mult     (wts_to_mult),
        .ips_to_mult     (ips_to_mult),
        .wts_inds_comp   (wts_inds_comp),
        .ips_inds_comp   (ips_inds_comp),
        .wts_offset      (wts_offset),
        .ips_offset      (ips_offset),
        .wt_dim          (wt_dim),
        .ip_dim          (ip_dim),
        .out_valid       (out_valid),
        .ops_from_mult   (ops_from_mult),
        .ops_cords       (ops_cords),
        .original_wt_ind (original_wt_ind),
        .original_ip_ind (original_ip_ind),
        .last_wt_ind     (last_wt_ind),
        .last_ip_ind     (last_ip_ind)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_geom(input logic [3:0] woff, input logic [7:0] ioff,
                            input logic [3:0] r_dim, input logic [7:0] w_side);
        wts_offset = woff;
        ips_offset = ioff;
        wt_dim     = r_dim;
        ip_dim     = w_side;
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b1;
        in_valid      = 1'b0;
        wts_to_mult   = '0;
        ips_to_mult   = '0;
        wts_inds_comp = '0;
        ips_inds_comp = '0;
        set_geom(4'd0, 8'd0, 4'd3, 8'd10);

        // Asynchronous reset takes effect before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid",   32'(out_valid),    32'd0);
        chk("rst_cord0",   32'(ops_cords[0]), 32'hFF);
        chk("rst_cord15",  32'(ops_cords[15]), 32'hFF);
        chk("rst_prod0",   ops_from_mult[0],  32'd0);
        chk("rst_orig_ip", original_ip_ind,   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Dense start
        wts_to_mult = {16'd1, 16'd1, 16'd1, 16'd1};
        ips_to_mult = {16'd3, 16'd3, 16'd3, 16'd3};
        set_geom(4'd0, 8'd0, 4'd3, 8'd10);
        in_valid = 1'b1;
        step();
        chk("t1_valid",   32'(out_valid),        32'd1);
        chk("t1_orig_ip", original_ip_ind,       32'h03020100);
        chk("t1_orig_wt", 32'(original_wt_ind),  32'h3210);
        chk("t1_cord0",   32'(ops_cords[0]),     32'h00);
        chk("t1_cord2",   32'(ops_cords[2]),     32'h02);
        chk("t1_cord5",   32'(ops_cords[5]),     32'h00);
        chk("t1_cord4",   32'(ops_cords[4]),     32'hFF);
        chk("t1_cord15",  32'(ops_cords[15]),    32'hFF);
        chk("t1_prod0",   ops_from_mult[0],      32'd3);

        // Idle cycle: data held, valid drops
        in_valid   = 1'b0;
        ips_offset = 8'd50;
        wts_to_mult[0] = 16'd9;
        step();
        chk("hold_valid",   32'(out_valid),    32'd0);
        chk("hold_cord0",   32'(ops_cords[0]), 32'h00);
        chk("hold_orig_ip", original_ip_ind,   32'h03020100);
        chk("hold_prod0",   ops_from_mult[0],  32'd3);

        // Runs and offset
        ips_inds_comp = {8'd1, 8'd5, 8'd0, 8'd2};
        wts_inds_comp = {4'd0, 4'd0, 4'd0, 4'd4};
        set_geom(4'd0, 8'd10, 4'd3, 8'd10);
        in_valid = 1'b1;
        step();
        chk("t2_orig_ip", original_ip_ind,      32'h15130D0C);
        chk("t2_last_ip", 32'(last_ip_ind),     32'd21);
        chk("t2_orig_wt", 32'(original_wt_ind), 32'h7654);
        chk("t2_cord3",   32'(ops_cords[3]),    32'd8);
        chk("t2_cord0",   32'(ops_cords[0]),    32'd1);
        chk("t2_cord1",   32'(ops_cords[1]),    32'd2);
        chk("t2_cord2",   32'(ops_cords[2]),    32'hFF);
        chk("t2_cord13",  32'(ops_cords[13]),   32'hFF);
        chk("t2_cord15",  32'(ops_cords[15]),   32'd0);

        // Signed multiply, followed back-to-back by a second set
        wts_to_mult = {16'd7, 16'd0, 16'hFFFD, 16'd2};
        ips_to_mult = {16'd32767, 16'hFFFF, 16'd4, 16'd5};
        step();
        chk("t3_valid",  32'(out_valid),     32'd1);
        chk("t3_prod0",  ops_from_mult[0],   32'd10);
        chk("t3_prod5",  ops_from_mult[5],   32'hFFFFFFF4);
        chk("t3_prod7",  ops_from_mult[7],   32'hFFFE8003);
        for (int i = 8; i < 12; i++) chk("t3_prod_zero", ops_from_mult[i], 32'd0);
        chk("t3_prod14", ops_from_mult[14],  32'hFFFFFFF9);
        chk("t3_prod15", ops_from_mult[15],  32'd229369);

        wts_to_mult[0] = 16'h8000;
        ips_to_mult[0] = 16'h8000;
        ips_to_mult[1] = 16'd32767;
        step();
        chk("b2b_valid", 32'(out_valid),   32'd1);
        chk("b2b_prod0", ops_from_mult[0], 32'h40000000);
        chk("b2b_prod1", ops_from_mult[1], 32'hC0008000);

        // Weight overrun past R*R; activations placed where geometry alone would accept q=9
        wts_inds_comp = '0;
        ips_inds_comp = '0;
        set_geom(4'd7, 8'd30, 4'd3, 8'd10);
        step();
        chk("t4_orig_wt", 32'(original_wt_ind), 32'hA987);
        chk("t4_last_wt", 32'(last_wt_ind),     32'hA);
        for (int i = 8; i < 16; i++) chk("t4_cord_ovr", 32'(ops_cords[i]), 32'hFF);
        chk("t4_cord1",   32'(ops_cords[1]),    32'd8);
        chk("t4_cord6",   32'(ops_cords[6]),    32'd8);

        // Coordinate ceiling and index truncation: W=200, R=1
        set_geom(4'd0, 8'd254, 4'd1, 8'd200);
        step();
        chk("t5_cord0",   32'(ops_cords[0]),    32'hFE);
        chk("t5_cord1",   32'(ops_cords[1]),    32'hFF);
        chk("t5_cord4",   32'(ops_cords[4]),    32'hFF);
        chk("t5_orig_ip", original_ip_ind,      32'h0100FFFE);
        chk("t5_last_ip", 32'(last_ip_ind),     32'd1);

        // Zero filter side invalidates every entry
        set_geom(4'd0, 8'd0, 4'd0, 8'd10);
        step();
        chk("t6_cord0", 32'(ops_cords[0]), 32'hFF);
        chk("t6_cord5", 32'(ops_cords[5]), 32'hFF);

        // Reset mid-stream clears immediately, then reload
        wts_to_mult = {16'd1, 16'd1, 16'd1, 16'd1};
        ips_to_mult = {16'd3, 16'd3, 16'd3, 16'd3};
        set_geom(4'd0, 8'd0, 4'd3, 8'd10);
        step();
        chk("pre_rst_cord0", 32'(ops_cords[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",   32'(out_valid),    32'd0);
        chk("mid_rst_cord0",   32'(ops_cords[0]), 32'hFF);
        chk("mid_rst_prod0",   ops_from_mult[0],  32'd0);
        chk("mid_rst_orig_wt", 32'(original_wt_ind), 32'd0);
        chk("mid_rst_last_wt", 32'(last_wt_ind),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid),    32'd1);
        chk("post_rst_cord2", 32'(ops_cords[2]), 32'd2);
        chk("post_rst_prod0", ops_from_mult[0],  32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
